// File: rtl/csr_pkg.sv
// csr_pkg: shared constants for the machine/user CSR file and trap controller.
// Holds CSR addresses, mstatus field positions, trap cause codes, privilege
// encodings, mtvec modes and the small legalisation helpers used on writes.
package csr_pkg;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  // mstatus field positions
  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  // Trap cause codes (exceptions and interrupts share the 4-bit code field)
  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_BREAK   = 4'd3;
  localparam logic [3:0] CAUSE_ECALL_U = 4'd8;
  localparam logic [3:0] CAUSE_ECALL_M = 4'd11;
  localparam logic [3:0] IRQ_SOFT      = 4'd3;
  localparam logic [3:0] IRQ_TIMER     = 4'd7;
  localparam logic [3:0] IRQ_EXT       = 4'd11;

  // Privilege encodings
  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_M = 2'b11;

  // mtvec modes
  localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  // Only M and U exist, so any other MPP value collapses to U.
  function automatic logic [1:0] legal_mpp(input logic [1:0] v);
    return (v == PRIV_M) ? PRIV_M : PRIV_U;
  endfunction

  // Reserved modes (2 and 3) fall back to direct.
  function automatic logic [1:0] legal_mtvec_mode(input logic [1:0] m);
    return m[1] ? MTVEC_DIRECT : m;
  endfunction

endpackage

// File: rtl/sys_ops_if.sv
// sys_ops_if: decoded system-instruction bundle from decode to the CSR/trap unit.
// Fields: csrrw/csrrs/csrrc/ecall/ebreak/mret one-hot op flags, csr_addr[11:0].
// Modports: src (decoder side, drives), dst (CSR unit side, consumes).
interface sys_ops_if;
  logic        csrrw_op;
  logic        csrrs_op;
  logic        csrrc_op;
  logic        ecall_op;
  logic        ebreak_op;
  logic        mret_op;
  logic [11:0] csr_addr;

  modport src (output csrrw_op, csrrs_op, csrrc_op, ecall_op, ebreak_op, mret_op, csr_addr);
  modport dst (input  csrrw_op, csrrs_op, csrrc_op, ecall_op, ebreak_op, mret_op, csr_addr);
endinterface

// File: rtl/csr_counter.sv
// csr_counter: W-bit free-running counter with increment enable and a
// CSR write port that overrides the increment in the same cycle.
// Ports: clk_i, rst_i (async, active-high), inc_i, we_i, wdata_i[W-1:0],
//        count_o[W-1:0] (current value, wraps from all-ones to zero).
module csr_counter #(
  parameter int unsigned W = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         we_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  // Next count: a software write beats the increment.
  always_comb begin
    if (we_i) begin
      count_d = wdata_i;
    end else if (inc_i) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/csr_trap_unit_chk.sv
// csr_trap_unit_chk: protocol checker for the CSR/trap unit.
// Ports: clk_i, rst_i, retire_i, trap_en_i.
module csr_trap_unit_chk (
  input logic clk_i,
  input logic rst_i,
  input logic retire_i,
  input logic trap_en_i
);

  // A trapping instruction is squashed by the caller, so it must never retire.
  retire_on_trap_a: assert property (@(posedge clk_i) disable iff (rst_i) !(retire_i && trap_en_i));

endmodule

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: M/U-mode CSR file and trap controller for the execute stage.
// Ports: clk, rst (async, active-high); sys_ops (decoded op bundle);
//   valid (instruction at execute), retire (instruction retired), pc, data1 (rs1),
//   imm (zero-extended uimm), with_imm (select imm as write source),
//   irq_ext/irq_soft/irq_timer (level interrupts);
//   csr_data (old CSR value for rd), trap_en/trap_pc (fetch redirect), priv.
// Outputs are combinational from pre-update state; all state changes land
// on the next clock edge.
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter int unsigned     XLEN      = 64,  // 32 or 64
  parameter logic [XLEN-1:0] HARTID    = '0,
  parameter logic [XLEN-1:0] MTVEC_RST = '0,
  parameter logic [XLEN-1:0] MISA_VAL  = {((XLEN == 64) ? 2'b10 : 2'b01), {(XLEN-28){1'b0}}, 26'h0101100}
) (
  input  logic            clk,
  input  logic            rst,
  sys_ops_if.dst          sys_ops,
  input  logic            valid,
  input  logic            retire,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] imm,
  input  logic            with_imm,
  input  logic            irq_ext,
  input  logic            irq_soft,
  input  logic            irq_timer,
  output logic [XLEN-1:0] csr_data,
  output logic            trap_en,
  output logic [XLEN-1:0] trap_pc,
  output logic [1:0]      priv
);

  localparam logic [XLEN-1:0] IRQ_MASK = XLEN'(12'h888);

  logic [1:0]      priv_q, priv_d;
  logic            st_mie_q, st_mie_d;
  logic            st_mpie_q, st_mpie_d;
  logic [1:0]      st_mpp_q, st_mpp_d;
  logic [XLEN-1:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [XLEN-1:0] mcycle_s, minstret_s, mstatus_s, mip_s, pend_s;
  logic [XLEN-1:0] wdata_s, csr_old_s, csr_new_s, tvec_base_s, exc_tval_s;
  logic            csr_op_s, csr_impl_s, csr_wr_s, csr_ro_s, csr_illegal_s, csr_we_s;
  logic            irq_take_s, exc_s, exc_take_s, mret_take_s, trap_take_s;
  logic [3:0]      irq_code_s, exc_code_s, cause_code_s;

  // Architectural views of mstatus and mip.
  always_comb begin
    mstatus_s = '0;
    mstatus_s[MSTATUS_MIE] = st_mie_q;
    mstatus_s[MSTATUS_MPIE] = st_mpie_q;
    mstatus_s[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = st_mpp_q;
    mip_s = '0;
    mip_s[IRQ_SOFT] = irq_soft;
    mip_s[IRQ_TIMER] = irq_timer;
    mip_s[IRQ_EXT] = irq_ext;
  end

  assign csr_op_s = sys_ops.csrrw_op | sys_ops.csrrs_op | sys_ops.csrrc_op;
  assign wdata_s  = with_imm ? imm : data1;
  // Set/clear with a zero operand only reads, so it may target read-only CSRs.
  assign csr_wr_s = sys_ops.csrrw_op | ((sys_ops.csrrs_op | sys_ops.csrrc_op) & (wdata_s != '0));
  assign csr_ro_s = (sys_ops.csr_addr[11:10] == 2'b11) || (sys_ops.csr_addr == CSR_MISA) ||
                    (sys_ops.csr_addr == CSR_MIP);

  // CSR read mux and implemented-address decode.
  always_comb begin
    csr_old_s  = '0;
    csr_impl_s = 1'b1;
    case (sys_ops.csr_addr)
      CSR_MSTATUS:  csr_old_s = mstatus_s;
      CSR_MISA:     csr_old_s = MISA_VAL;
      CSR_MIE:      csr_old_s = mie_q;
      CSR_MTVEC:    csr_old_s = mtvec_q;
      CSR_MSCRATCH: csr_old_s = mscratch_q;
      CSR_MEPC:     csr_old_s = mepc_q;
      CSR_MCAUSE:   csr_old_s = mcause_q;
      CSR_MTVAL:    csr_old_s = mtval_q;
      CSR_MIP:      csr_old_s = mip_s;
      CSR_MCYCLE:   csr_old_s = mcycle_s;
      CSR_MINSTRET: csr_old_s = minstret_s;
      CSR_MHARTID:  csr_old_s = HARTID;
      default:      csr_impl_s = 1'b0;
    endcase
  end

  assign csr_illegal_s = csr_op_s && (!csr_impl_s || (sys_ops.csr_addr[9:8] > priv_q) ||
                                      (csr_wr_s && csr_ro_s));
  assign csr_new_s = sys_ops.csrrw_op ? wdata_s :
                     sys_ops.csrrs_op ? (csr_old_s | wdata_s) : (csr_old_s & ~wdata_s);

  // Interrupt decision uses pre-update MIE/priv, so a same-cycle write cannot mask it.
  assign pend_s     = mip_s & mie_q;
  assign irq_take_s = valid && ((priv_q == PRIV_U) || st_mie_q) && (pend_s != '0);

  // Fixed interrupt priority: external, then software, then timer.
  always_comb begin
    if (pend_s[IRQ_EXT]) begin
      irq_code_s = IRQ_EXT;
    end else if (pend_s[IRQ_SOFT]) begin
      irq_code_s = IRQ_SOFT;
    end else begin
      irq_code_s = IRQ_TIMER;
    end
  end

  // Synchronous exception detection; decode guarantees at most one op.
  always_comb begin
    exc_s      = 1'b0;
    exc_code_s = CAUSE_ILLEGAL;
    exc_tval_s = '0;
    if (csr_illegal_s || (sys_ops.mret_op && (priv_q == PRIV_U))) begin
      exc_s = 1'b1;
    end else if (sys_ops.ecall_op) begin
      exc_s      = 1'b1;
      exc_code_s = (priv_q == PRIV_U) ? CAUSE_ECALL_U : CAUSE_ECALL_M;
    end else if (sys_ops.ebreak_op) begin
      exc_s      = 1'b1;
      exc_code_s = CAUSE_BREAK;
      exc_tval_s = pc;
    end else begin
      exc_s = 1'b0;
    end
  end

  assign exc_take_s   = valid && !irq_take_s && exc_s;
  assign mret_take_s  = valid && !irq_take_s && sys_ops.mret_op && (priv_q == PRIV_M);
  assign trap_take_s  = irq_take_s || exc_take_s;
  assign csr_we_s     = valid && !irq_take_s && csr_op_s && csr_wr_s && !csr_illegal_s;
  assign cause_code_s = irq_take_s ? irq_code_s : exc_code_s;
  assign tvec_base_s  = {mtvec_q[XLEN-1:2], 2'b00};

  // Redirect and rd data; reset masks them so a mid-reset op has no visible effect.
  always_comb begin
    trap_en  = !rst && (trap_take_s || mret_take_s);
    csr_data = '0;
    trap_pc  = '0;
    if (!rst && valid && !irq_take_s && csr_op_s && !csr_illegal_s) begin
      csr_data = csr_old_s;
    end else begin
      csr_data = '0;
    end
    if (rst) begin
      trap_pc = '0;
    end else if (mret_take_s) begin
      trap_pc = mepc_q;
    end else if (irq_take_s && (mtvec_q[1:0] == MTVEC_VECTORED)) begin
      trap_pc = tvec_base_s + XLEN'({irq_code_s, 2'b00});
    end else if (trap_take_s) begin
      trap_pc = tvec_base_s;
    end else begin
      trap_pc = '0;
    end
  end

  // Next-state for privilege and CSRs: trap entry, then mret, then CSR write.
  always_comb begin
    priv_d     = priv_q;
    st_mie_d   = st_mie_q;
    st_mpie_d  = st_mpie_q;
    st_mpp_d   = st_mpp_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (trap_take_s) begin
      mepc_d    = {pc[XLEN-1:1], 1'b0};
      mcause_d  = {irq_take_s, {(XLEN-5){1'b0}}, cause_code_s};
      mtval_d   = irq_take_s ? mtval_q : exc_tval_s;
      st_mpie_d = st_mie_q;
      st_mie_d  = 1'b0;
      st_mpp_d  = priv_q;
      priv_d    = PRIV_M;
    end else if (mret_take_s) begin
      st_mie_d  = st_mpie_q;
      st_mpie_d = 1'b1;
      priv_d    = st_mpp_q;
      st_mpp_d  = PRIV_U;
    end else if (csr_we_s) begin
      case (sys_ops.csr_addr)
        CSR_MSTATUS: begin
          st_mie_d  = csr_new_s[MSTATUS_MIE];
          st_mpie_d = csr_new_s[MSTATUS_MPIE];
          st_mpp_d  = legal_mpp(csr_new_s[MSTATUS_MPP_HI:MSTATUS_MPP_LO]);
        end
        CSR_MIE:      mie_d      = csr_new_s & IRQ_MASK;
        CSR_MTVEC:    mtvec_d    = {csr_new_s[XLEN-1:2], legal_mtvec_mode(csr_new_s[1:0])};
        CSR_MSCRATCH: mscratch_d = csr_new_s;
        CSR_MEPC:     mepc_d     = {csr_new_s[XLEN-1:1], 1'b0};
        CSR_MCAUSE:   mcause_d   = csr_new_s;
        CSR_MTVAL:    mtval_d    = csr_new_s;
        default:      mtval_d    = mtval_q;  // counters are written through their own instances
      endcase
    end else begin
      priv_d = priv_q;
    end
  end

  // Architectural state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      priv_q     <= PRIV_M;
      st_mie_q   <= 1'b0;
      st_mpie_q  <= 1'b0;
      st_mpp_q   <= PRIV_U;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      priv_q     <= priv_d;
      st_mie_q   <= st_mie_d;
      st_mpie_q  <= st_mpie_d;
      st_mpp_q   <= st_mpp_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

  csr_counter #(.W(XLEN)) u_mcycle (
    .clk_i(clk), .rst_i(rst), .inc_i(1'b1),
    .we_i(csr_we_s && (sys_ops.csr_addr == CSR_MCYCLE)),
    .wdata_i(csr_new_s), .count_o(mcycle_s)
  );

  csr_counter #(.W(XLEN)) u_minstret (
    .clk_i(clk), .rst_i(rst), .inc_i(retire),
    .we_i(csr_we_s && (sys_ops.csr_addr == CSR_MINSTRET)),
    .wdata_i(csr_new_s), .count_o(minstret_s)
  );

  csr_trap_unit_chk u_chk (
    .clk_i(clk), .rst_i(rst), .retire_i(retire), .trap_en_i(trap_en)
  );

  assign priv = priv_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed self-checking bench for csr_trap_unit (XLEN=64, default parameters).
module tb_csr_trap_unit;

  logic        clk, rst, valid, retire, with_imm;
  logic        irq_ext, irq_soft, irq_timer;
  logic [63:0] pc, data1, imm, csr_data, trap_pc;
  logic        trap_en;
  logic [1:0]  priv;
  int          vectors;
  int          miscompares;

  sys_ops_if ops ();

  csr_trap_unit #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .sys_ops(ops), .valid(valid), .retire(retire),
    .pc(pc), .data1(data1), .imm(imm), .with_imm(with_imm),
    .irq_ext(irq_ext), .irq_soft(irq_soft), .irq_timer(irq_timer),
    .csr_data(csr_data), .trap_en(trap_en), .trap_pc(trap_pc), .priv(priv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ops.csrrw_op = 1'b0; ops.csrrs_op = 1'b0; ops.csrrc_op = 1'b0;
    ops.ecall_op = 1'b0; ops.ebreak_op = 1'b0; ops.mret_op = 1'b0;
    ops.csr_addr = 12'h000;
    valid = 1'b0; retire = 1'b0; with_imm = 1'b0; data1 = 64'd0; imm = 64'd0;
  endtask

  // Advance to 1 time unit after the next rising edge, then drop all ops.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  // Present a CSR op (kind 0=rw, 1=rs, 2=rc) and settle to the falling edge.
  task automatic csr_op(input int kind, input logic [11:0] a, input logic [63:0] wd);
    ops.csrrw_op = (kind == 0);
    ops.csrrs_op = (kind == 1);
    ops.csrrc_op = (kind == 2);
    ops.csr_addr = a;
    data1 = wd;
    valid = 1'b1;
    #4;
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] wd);
    csr_op(0, a, wd);
    tick();
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [63:0] exp);
    csr_op(1, a, 64'd0);
    check(tag, csr_data, exp);
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    idle();
    irq_ext = 1'b0; irq_soft = 1'b0; irq_timer = 1'b0;
    pc = 64'd0;

    // Reset: a read of misa presented during reset must be masked.
    @(posedge clk);
    #1;
    csr_op(1, 12'h301, 64'd0);
    check("rst_csr_data", csr_data, 64'd0);
    check("rst_trap_en", {63'd0, trap_en}, 64'd0);
    check("rst_trap_pc", trap_pc, 64'd0);
    check("rst_priv", {62'd0, priv}, 64'd3);
    tick();
    rst = 1'b0;
    rd_chk("rst_mstatus", 12'h300, 64'd0);
    rd_chk("rst_mtvec", 12'h305, 64'd0);

    // ecall from M
    wr(12'h305, 64'h8000_0000);
    pc = 64'h100; ops.ecall_op = 1'b1; valid = 1'b1; #4;
    check("ecall_trap_en", {63'd0, trap_en}, 64'd1);
    check("ecall_trap_pc", trap_pc, 64'h8000_0000);
    tick();
    rd_chk("ecall_mcause", 12'h342, 64'd11);
    rd_chk("ecall_mepc", 12'h341, 64'h100);
    rd_chk("ecall_mstatus", 12'h300, 64'h1800);

    // mret to U, then an illegal CSR access from U
    wr(12'h300, 64'h80);
    wr(12'h341, 64'h200);
    ops.mret_op = 1'b1; valid = 1'b1; #4;
    check("mret_trap_en", {63'd0, trap_en}, 64'd1);
    check("mret_trap_pc", trap_pc, 64'h200);
    tick();
    check("mret_priv", {62'd0, priv}, 64'd0);
    csr_op(0, 12'h340, 64'hDEAD);
    check("u_ill_trap_en", {63'd0, trap_en}, 64'd1);
    check("u_ill_trap_pc", trap_pc, 64'h8000_0000);
    check("u_ill_csr_data", csr_data, 64'd0);
    tick();
    check("u_ill_priv", {62'd0, priv}, 64'd3);
    rd_chk("u_ill_mcause", 12'h342, 64'd2);
    rd_chk("u_ill_mscratch", 12'h340, 64'd0);
    rd_chk("u_ill_mstatus", 12'h300, 64'h80);
    rd_chk("u_ill_mtval", 12'h343, 64'd0);

    // Vectored external interrupt pre-empts a csrrw
    wr(12'h340, 64'h11);
    wr(12'h305, 64'h1001);
    wr(12'h304, 64'h800);
    csr_op(1, 12'h300, 64'h8); tick();
    irq_ext = 1'b1; pc = 64'h300;
    csr_op(0, 12'h340, 64'h55);
    check("vec_trap_en", {63'd0, trap_en}, 64'd1);
    check("vec_trap_pc", trap_pc, 64'h102C);
    check("vec_csr_data", csr_data, 64'd0);
    tick();
    irq_ext = 1'b0;
    rd_chk("vec_mcause", 12'h342, 64'h8000_0000_0000_000B);
    rd_chk("vec_mscratch", 12'h340, 64'h11);
    rd_chk("vec_mepc", 12'h341, 64'h300);
    rd_chk("vec_mstatus", 12'h300, 64'h1880);

    // Priority among simultaneous interrupts
    wr(12'h304, 64'h888);
    csr_op(1, 12'h300, 64'h8); tick();
    irq_ext = 1'b1; irq_soft = 1'b1; irq_timer = 1'b1;
    valid = 1'b1; #4;
    check("prio_all_trap_pc", trap_pc, 64'h102C);
    tick();
    rd_chk("prio_all_mcause", 12'h342, 64'h8000_0000_0000_000B);
    rd_chk("prio_mip", 12'h344, 64'h888);
    irq_ext = 1'b0;
    csr_op(1, 12'h300, 64'h8);
    check("prio_mie0_no_trap", {63'd0, trap_en}, 64'd0);
    tick();
    valid = 1'b1; #4;
    check("prio_soft_trap_pc", trap_pc, 64'h100C);
    tick();
    irq_soft = 1'b0; irq_timer = 1'b0;
    rd_chk("prio_soft_mcause", 12'h342, 64'h8000_0000_0000_0003);

    // Counter write override and wrap
    wr(12'hB00, 64'd5);
    rd_chk("mcycle_wr", 12'hB00, 64'd5);
    rd_chk("mcycle_inc", 12'hB00, 64'd6);
    wr(12'hB02, 64'hFFFF_FFFF_FFFF_FFFF);
    retire = 1'b1; #4;
    tick();
    rd_chk("minstret_wrap", 12'hB02, 64'd0);

    // Illegal and legalising writes
    csr_op(0, 12'h301, 64'd0);
    check("misa_wr_trap_en", {63'd0, trap_en}, 64'd1);
    check("misa_wr_trap_pc", trap_pc, 64'h1000);
    tick();
    rd_chk("misa_wr_mcause", 12'h342, 64'd2);
    csr_op(1, 12'h301, 64'd0);
    check("misa_rd_trap_en", {63'd0, trap_en}, 64'd0);
    check("misa_rd_data", csr_data, 64'h8000_0000_0010_1100);
    tick();
    wr(12'h305, 64'h2003);
    rd_chk("mtvec_mode_legal", 12'h305, 64'h2000);
    wr(12'h341, 64'h201);
    rd_chk("mepc_bit0", 12'h341, 64'h200);
    wr(12'h300, 64'h1000);
    rd_chk("mpp_legal", 12'h300, 64'd0);

    // ebreak
    pc = 64'h400; ops.ebreak_op = 1'b1; valid = 1'b1; #4;
    check("ebreak_trap_pc", trap_pc, 64'h2000);
    tick();
    rd_chk("ebreak_mcause", 12'h342, 64'd3);
    rd_chk("ebreak_mtval", 12'h343, 64'h400);

    // Async reset in the middle of a trapping op from U
    wr(12'h300, 64'd0);
    wr(12'h341, 64'h600);
    ops.mret_op = 1'b1; valid = 1'b1; #4;
    check("mret2_trap_pc", trap_pc, 64'h600);
    tick();
    check("mret2_priv", {62'd0, priv}, 64'd0);
    pc = 64'h500; ops.ecall_op = 1'b1; valid = 1'b1; #2;
    check("rst_mid_pre_trap_en", {63'd0, trap_en}, 64'd1);
    rst = 1'b1; #1;
    check("rst_mid_trap_en", {63'd0, trap_en}, 64'd0);
    check("rst_mid_priv", {62'd0, priv}, 64'd3);
    @(posedge clk);
    #1;
    idle();
    rst = 1'b0;
    rd_chk("rst_mid_mepc", 12'h341, 64'd0);
    rd_chk("rst_mid_mtvec", 12'h305, 64'd0);
    rd_chk("rst_mid_mcause", 12'h342, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
